// File: rtl/pix_mem_arbiter_pkg.sv
// Shared types and constants for the pixel memory arbiter and its VGA timing source.
// Holds the owner encoding, default image size and the standard VGA timing numbers.
package pix_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_FLT  = 2'd2
    } owner_t;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    // 640x480 @ 60 Hz
    localparam int H640_ACTIVE = 640;
    localparam int H640_FP     = 16;
    localparam int H640_SYNC   = 96;
    localparam int H640_BP     = 48;
    localparam int H640_TOTAL  = 800;
    localparam int V640_ACTIVE = 480;
    localparam int V640_FP     = 10;
    localparam int V640_SYNC   = 2;
    localparam int V640_BP     = 33;
    localparam int V640_TOTAL  = 525;

    // 800x600 @ 60 Hz
    localparam int H800_ACTIVE = 800;
    localparam int H800_FP     = 40;
    localparam int H800_SYNC   = 128;
    localparam int H800_BP     = 88;
    localparam int H800_TOTAL  = 1056;
    localparam int V800_ACTIVE = 600;
    localparam int V800_FP     = 1;
    localparam int V800_SYNC   = 4;
    localparam int V800_BP     = 23;
    localparam int V800_TOTAL  = 628;

endpackage

// File: rtl/pix_mem_arbiter_addr_gen.sv
// Combinational linear pixel address y*IMG_W+x, built as a shift-add over the set bits of IMG_W.
// Zero latency, no flow control.
module pix_addr_gen #(
    parameter int IMG_W = 640,
    parameter int AW    = 19
) (
    input  logic [9:0]    x_pix,
    input  logic [9:0]    y_pix,
    output logic [AW-1:0] addr
);

    // IMG_W is elaboration-time constant, so each term is a fixed shift of y.
    always_comb begin
        addr = AW'(x_pix);
        for (int i = 0; i < 31; i++) begin
            if (IMG_W[i]) begin
                addr = addr + (AW'(y_pix) << i);
            end
        end
    end

endmodule

// File: rtl/pix_mem_arbiter.sv
// Single-port pixel memory arbiter: VGA scan-out always wins in-image, filter gets blanking cycles.
// Grant is combinational, read data returns 1 cycle after issue; filter holds its request until granted.
module pix_mem_arbiter
    import pix_mem_arbiter_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int DW    = 8,
    parameter int AW    = 19
) (
    input  logic          sclk,
    input  logic          rst,
    input  logic          video_on,
    input  logic [9:0]    x_pix,
    input  logic [9:0]    y_pix,
    output logic [DW-1:0] vga_rdata,
    output logic          vga_valid,
    input  logic          flt_req,
    input  logic          flt_we,
    input  logic [AW-1:0] flt_addr,
    input  logic [DW-1:0] flt_wdata,
    output logic          flt_gnt,
    output logic [DW-1:0] flt_rdata,
    output logic          flt_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [31:0] IMG_W_U = 32'(IMG_W);
    localparam logic [31:0] IMG_H_U = 32'(IMG_H);

    owner_t        owner_q, owner_d;
    logic          flt_rd_q, flt_rd_d;
    logic          blank_q, blank_d;
    logic          in_image;
    logic [AW-1:0] pix_addr;

    pix_addr_gen #(
        .IMG_W (IMG_W),
        .AW    (AW)
    ) u_addr_gen (
        .x_pix (x_pix),
        .y_pix (y_pix),
        .addr  (pix_addr)
    );

    assign in_image = video_on && (32'(x_pix) < IMG_W_U) && (32'(y_pix) < IMG_H_U);

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            flt_rd_q <= 1'b0;
            blank_q  <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            flt_rd_q <= flt_rd_d;
            blank_q  <= blank_d;
        end
    end

    // Memory ports are gated by rst so nothing is issued while reset is held.
    always_comb begin
        owner_d   = OWN_NONE;
        flt_rd_d  = 1'b0;
        blank_d   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = flt_addr;
        mem_wdata = flt_wdata;
        flt_gnt   = 1'b0;
        if (!rst) begin
            if (in_image) begin
                mem_en   = 1'b1;
                mem_addr = pix_addr;
                owner_d  = OWN_VGA;
            end else begin
                blank_d = video_on;
                if (flt_req) begin
                    flt_gnt  = 1'b1;
                    mem_en   = 1'b1;
                    mem_we   = flt_we;
                    owner_d  = OWN_FLT;
                    flt_rd_d = !flt_we;
                end
            end
        end
    end

    // Blank pixels inside video_on still produce a (black) display sample.
    assign vga_valid  = (owner_q == OWN_VGA) || blank_q;
    assign vga_rdata  = (owner_q == OWN_VGA) ? mem_rdata : '0;
    assign flt_rvalid = (owner_q == OWN_FLT) && flt_rd_q;
    assign flt_rdata  = flt_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_pix_mem_arbiter.sv
// Bench for pix_mem_arbiter: directed corner sequences, a vector table and a random run vs a reference model.
module tb_pix_mem_arbiter;

    localparam int IMG_W = 640;
    localparam int IMG_H = 480;
    localparam int DW    = 8;
    localparam int AW    = 19;
    localparam int MEMN  = 1 << AW;

    logic          sclk;
    logic          rst;
    logic          video_on;
    logic [9:0]    x_pix;
    logic [9:0]    y_pix;
    logic [DW-1:0] vga_rdata;
    logic          vga_valid;
    logic          flt_req;
    logic          flt_we;
    logic [AW-1:0] flt_addr;
    logic [DW-1:0] flt_wdata;
    logic          flt_gnt;
    logic [DW-1:0] flt_rdata;
    logic          flt_rvalid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    pix_mem_arbiter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .DW    (DW),
        .AW    (AW)
    ) dut (
        .sclk       (sclk),
        .rst        (rst),
        .video_on   (video_on),
        .x_pix      (x_pix),
        .y_pix      (y_pix),
        .vga_rdata  (vga_rdata),
        .vga_valid  (vga_valid),
        .flt_req    (flt_req),
        .flt_we     (flt_we),
        .flt_addr   (flt_addr),
        .flt_wdata  (flt_wdata),
        .flt_gnt    (flt_gnt),
        .flt_rdata  (flt_rdata),
        .flt_rvalid (flt_rvalid),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    function automatic logic [7:0] hsh(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h3C;
    endfunction

    // Synchronous single-port memory the DUT talks to.
    logic [DW-1:0] bmem [0:MEMN-1];
    initial begin
        for (int i = 0; i < MEMN; i++) bmem[i] = hsh(AW'(i));
        mem_rdata = '0;
        forever begin
            @(posedge sclk);
            if (mem_en) begin
                if (mem_we) bmem[mem_addr] = mem_wdata;
                else        mem_rdata <= bmem[mem_addr];
            end
        end
    end

    // Reference model state: the image contents and what should come back next cycle.
    logic [DW-1:0] mmem [0:MEMN-1];
    bit            p_vv, p_fv;
    logic [DW-1:0] p_vd, p_fd;
    bit            e_en, e_we, e_gnt;
    logic [AW-1:0] e_addr;

    int errs = 0;
    int checks = 0;
    int gnt_seen = 0;
    int rv_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit von, input int x, input int y,
                        input bit req, input bit we, input logic [AW-1:0] a, input logic [7:0] wd);
        bit            in_img;
        logic [AW-1:0] pa;
        @(negedge sclk);
        rst = r; video_on = von; x_pix = 10'(x); y_pix = 10'(y);
        flt_req = req; flt_we = we; flt_addr = a; flt_wdata = wd;
        #1;
        e_en = 0; e_we = 0; e_gnt = 0; e_addr = '0;
        if (r) begin
            chk("rst_vga_valid", 32'(vga_valid), 0);
            chk("rst_vga_rdata", 32'(vga_rdata), 0);
            chk("rst_flt_rvalid", 32'(flt_rvalid), 0);
            chk("rst_flt_rdata", 32'(flt_rdata), 0);
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_flt_gnt", 32'(flt_gnt), 0);
            p_vv = 0; p_fv = 0;
        end else begin
            chk("vga_valid", 32'(vga_valid), 32'(p_vv));
            if (p_vv) chk("vga_rdata", 32'(vga_rdata), 32'(p_vd));
            chk("flt_rvalid", 32'(flt_rvalid), 32'(p_fv));
            if (p_fv) chk("flt_rdata", 32'(flt_rdata), 32'(p_fd));
            in_img = von && (x < IMG_W) && (y < IMG_H);
            pa = AW'(y * IMG_W + x);
            p_vv = 0; p_fv = 0;
            if (in_img) begin
                e_en = 1; e_addr = pa; p_vv = 1; p_vd = mmem[pa];
            end else begin
                if (von) begin p_vv = 1; p_vd = '0; end
                if (req) begin
                    e_gnt = 1; e_en = 1; e_we = we; e_addr = a;
                    if (we) mmem[a] = wd;
                    else begin p_fv = 1; p_fd = mmem[a]; end
                end
            end
            chk("mem_en", 32'(mem_en), 32'(e_en));
            chk("flt_gnt", 32'(flt_gnt), 32'(e_gnt));
            if (e_en) begin
                chk("mem_addr", 32'(mem_addr), 32'(e_addr));
                chk("mem_we", 32'(mem_we), 32'(e_we));
            end
            if (e_en && e_we) chk("mem_wdata", 32'(mem_wdata), 32'(wd));
        end
        if (flt_gnt) gnt_seen++;
        if (flt_rvalid) rv_seen++;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, '0, '0);
    endtask

    typedef struct {
        bit            von;
        int            x;
        int            y;
        bit            req;
        bit            we;
        logic [AW-1:0] a;
        logic [7:0]    wd;
        bit            x_en;
        bit            x_gnt;
        logic [AW-1:0] x_addr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int  g0;
        int  r0;
        bit  f_pend, f_we;
        logic [AW-1:0] f_a;
        logic [7:0]    f_wd;

        tbl[0] = '{1'b1,   5,    2, 1'b1, 1'b0, 19'd300,    8'h00, 1'b1, 1'b0, 19'd1285};
        tbl[1] = '{1'b0,   0,    0, 1'b1, 1'b0, 19'd100,    8'h00, 1'b1, 1'b1, 19'd100};
        tbl[2] = '{1'b1, 639,  479, 1'b0, 1'b0, 19'd0,      8'h00, 1'b1, 1'b0, 19'd307199};
        tbl[3] = '{1'b1, 639,  480, 1'b1, 1'b1, 19'd400000, 8'h5A, 1'b1, 1'b1, 19'd400000};
        tbl[4] = '{1'b1, 700,   10, 1'b0, 1'b0, 19'd0,      8'h00, 1'b0, 1'b0, 19'd0};
        tbl[5] = '{1'b0,  10,   10, 1'b1, 1'b0, 19'd524287, 8'h00, 1'b1, 1'b1, 19'd524287};
        tbl[6] = '{1'b1,   0,    0, 1'b0, 1'b0, 19'd0,      8'h00, 1'b1, 1'b0, 19'd0};
        tbl[7] = '{1'b1, 1023, 1023, 1'b1, 1'b0, 19'd42,    8'h00, 1'b1, 1'b1, 19'd42};

        for (int i = 0; i < MEMN; i++) mmem[i] = hsh(AW'(i));
        p_vv = 0; p_fv = 0; p_vd = '0; p_fd = '0;
        rst = 1'b1; video_on = 1'b0; x_pix = '0; y_pix = '0;
        flt_req = 1'b0; flt_we = 1'b0; flt_addr = '0; flt_wdata = '0;

        step(1, 0, 0, 0, 0, 0, '0, '0);
        step(1, 1, 5, 2, 1, 0, 19'd9, '0);
        idle();

        // In-image pixel beats a simultaneous filter request.
        step(0, 1, 5, 2, 1, 0, 19'd300, '0);
        chk("s1_addr", 32'(mem_addr), 1285);
        chk("s1_gnt", 32'(flt_gnt), 0);
        idle();
        chk("s1_vvalid", 32'(vga_valid), 1);
        chk("s1_vdata", 32'(vga_rdata), 32'(hsh(19'd1285)));

        // Filter read during blanking.
        step(0, 0, 0, 0, 1, 0, 19'd100, '0);
        chk("s2_gnt", 32'(flt_gnt), 1);
        chk("s2_addr", 32'(mem_addr), 100);
        idle();
        chk("s2_rvalid", 32'(flt_rvalid), 1);

        // Request held across ten active pixels, granted once on the first blank cycle.
        g0 = gnt_seen;
        for (int i = 0; i < 10; i++) step(0, 1, 10 + i, 3, 1, 0, 19'd200, '0);
        chk("s3_no_grant", 32'(gnt_seen - g0), 0);
        step(0, 0, 0, 0, 1, 0, 19'd200, '0);
        chk("s3_gnt", 32'(flt_gnt), 1);
        idle();
        idle();
        chk("s3_one_grant", 32'(gnt_seen - g0), 1);

        // Right edge of the line, then first pixel past it.
        step(0, 1, 639, 0, 0, 0, '0, '0);
        chk("s4_addr", 32'(mem_addr), 639);
        step(0, 1, 640, 0, 0, 0, '0, '0);
        chk("s4_no_en", 32'(mem_en), 0);
        chk("s4_v639", 32'(vga_rdata), 32'(hsh(19'd639)));
        idle();
        chk("s4_blank_valid", 32'(vga_valid), 1);
        chk("s4_blank_data", 32'(vga_rdata), 0);

        // Write then read back address 7.
        r0 = rv_seen;
        step(0, 0, 0, 0, 1, 1, 19'd7, 8'hA5);
        step(0, 0, 0, 0, 1, 0, 19'd7, '0);
        idle();
        chk("s5_rvalid", 32'(flt_rvalid), 1);
        chk("s5_rdata", 32'(flt_rdata), 32'hA5);
        idle();
        chk("s5_one_rvalid", 32'(rv_seen - r0), 1);

        // Reset right after a VGA grant drops the return; arbitration resumes straight after.
        step(0, 1, 5, 2, 0, 0, '0, '0);
        step(1, 0, 0, 0, 0, 0, '0, '0);
        chk("s6_no_vvalid", 32'(vga_valid), 0);
        idle();
        chk("s6_after_vvalid", 32'(vga_valid), 0);
        chk("s6_after_rvalid", 32'(flt_rvalid), 0);
        step(0, 1, 1, 1, 0, 0, '0, '0);
        chk("s6_resume", 32'(mem_en), 1);

        for (int i = 0; i < 8; i++) begin
            step(0, tbl[i].von, tbl[i].x, tbl[i].y, tbl[i].req, tbl[i].we, tbl[i].a, tbl[i].wd);
            chk($sformatf("tbl%0d_en", i), 32'(mem_en), 32'(tbl[i].x_en));
            chk($sformatf("tbl%0d_gnt", i), 32'(flt_gnt), 32'(tbl[i].x_gnt));
            if (tbl[i].x_en) chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].x_addr));
        end
        idle();

        // Random traffic; the filter keeps each request stable until it is granted.
        f_pend = 0; f_we = 0; f_a = '0; f_wd = '0;
        for (int n = 0; n < 3000; n++) begin
            bit r;
            if (!f_pend && ($urandom_range(0, 2) == 0)) begin
                f_pend = 1;
                f_we   = 1'($urandom_range(0, 1));
                f_a    = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, MEMN - 1))
                                                      : AW'($urandom_range(0, 63));
                f_wd   = 8'($urandom_range(0, 255));
            end
            r = ($urandom_range(0, 99) == 0);
            step(r, 1'($urandom_range(0, 1)), $urandom_range(0, 799),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 524) : $urandom_range(0, 1),
                 f_pend, f_we, f_a, f_wd);
            if (e_gnt) f_pend = 0;
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pix_mem_arbiter.md
PIX_MEM_ARBITER -- requirements
Module: pix_mem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- IMG_W  640  stored image width, pixels.
- IMG_H  480  stored image height, lines.
- DW  8  pixel data width.
- AW  19  memory address width; must satisfy 2^AW >= IMG_W*IMG_H.

REQ-002 Ports, one per line: name, direction, width, meaning.
- sclk  in  1  pixel clock, same clock as the VGA timing generator.
- rst  in  1  asynchronous, active-high reset.
- video_on  in  1  active-video flag from the timing generator.
- x_pix  in  10  current pixel column.
- y_pix  in  10  current pixel line.
- vga_rdata  out  DW  pixel data for display.
- vga_valid  out  1  vga_rdata is valid this cycle.
- flt_req  in  1  Sobel engine requests one memory access.
- flt_we  in  1  1 = write, 0 = read.
- flt_addr  in  AW  access address.
- flt_wdata  in  DW  write data.
- flt_gnt  out  1  access issued this cycle.
- flt_rdata  out  DW  read data.
- flt_rvalid  out  1  flt_rdata is valid.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; synchronous, 1-cycle latency.

REQ-003 Clock is sclk only. rst is asynchronous and active-high.

Function
REQ-004 Each cycle has exactly one memory owner, held in a registered owner field: OWN_NONE, OWN_VGA or OWN_FLT.
REQ-005 The display window is the in-image condition: video_on=1 AND x_pix<IMG_W AND y_pix<IMG_H.
REQ-006 In-image cycle: mem_en=1, mem_we=0, mem_addr=y_pix*IMG_W+x_pix computed at AW bits without overflow, owner becomes OWN_VGA. flt_gnt=0 regardless of flt_req.
REQ-007 Cycle with video_on=1 that is not in-image: no VGA memory access. The following cycle gives vga_valid=1 and vga_rdata=0.
REQ-008 Cycle with video_on=0: vga_valid=0 on the following cycle.
REQ-009 Cycle that is not in-image with flt_req=1: flt_gnt=1 combinationally, mem_en=1, mem_we=flt_we, mem_addr=flt_addr, mem_wdata=flt_wdata, owner becomes OWN_FLT.
REQ-010 Cycle that is not in-image with flt_req=0: mem_en=0, owner becomes OWN_NONE.
REQ-011 Read return, one cycle after issue:
- owner OWN_VGA gives vga_valid=1 and vga_rdata=mem_rdata.
- owner OWN_FLT with a read gives flt_rvalid=1 and flt_rdata=mem_rdata.
- A filter write gives flt_rvalid=0.
REQ-012 Handshake: the filter holds flt_req and all request fields stable until it sees flt_gnt=1. The request is consumed in the grant cycle. flt_req with no grant produces no side effects.
REQ-013 Simultaneous events:
- flt_req arriving in the same cycle the pixel becomes in-image: VGA wins.
- Back-to-back filter grants: allowed, one per cycle, rvalid pipelined.
REQ-014 Address wrap: a flt_addr at or beyond IMG_W*IMG_H is passed through unmodified.
REQ-015 VGA read data latency is exactly 1 cycle relative to the x_pix/y_pix sample.

Reset
REQ-016 While rst=1: owner=OWN_NONE, vga_valid=0, vga_rdata=0, flt_rvalid=0, flt_rdata=0, mem_en=0, mem_we=0, flt_gnt=0.
REQ-017 Reset asserted mid-access drops the pending return; no rvalid is issued after rst deasserts.
REQ-018 Normal arbitration resumes on the first sclk edge after rst deasserts.

Structure
REQ-019 A shared package holds:
- the owner enumeration;
- IMG_W/IMG_H defaults;
- the 640x480 and 800x600 timing constants used by the timing generator.
REQ-020 One sub-module, pix_addr_gen: registered-free y*IMG_W+x address calculation using shift-add when IMG_W is constant.

Verification
REQ-021 The bench covers these directed scenarios:
- x=5, y=2, video_on=1, IMG_W=640 -> mem_addr=1285, mem_en=1, flt_gnt=0; next cycle vga_valid=1, vga_rdata=mem_rdata.
- video_on=0, flt_req=1, flt_we=0, flt_addr=100 -> flt_gnt=1, mem_addr=100; next cycle flt_rvalid=1.
- flt_req held across 10 active pixels then blanking -> flt_gnt=0 for 10 cycles, then 1 on the first blank cycle, exactly one memory access.
- x=639 then x=640 with IMG_W=640, video_on=1 -> address 639*... read, then no mem_en; vga_rdata=0 with vga_valid=1.
- Filter write followed by a filter read to address 7 during blanking, data 0xA5 -> flt_rdata=0xA5, one rvalid only.
- rst asserted one cycle after a VGA grant -> no vga_valid; all outputs 0 during reset.
